kernel_stream_drain: RTL and testbench

Stream consumer for the output end of a kernel pipeline. It drives the ready signal back into a kernel top node and accepts that node's valid/data output stream. Accepted words are buffered in a small show-ahead FIFO and counted; the words are then handed to a host-side valid/ready port. The block sequences one job of a programmed length, reports completion, and can optionally fold every accepted word into a rotating checksum.

---
 rtl/kernel_stream_drain.sv | 99 +++++++++
 tb/tb_kernel_stream_drain.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/kernel_stream_drain.sv
// Kernel output stream consumer: show-ahead FIFO, job length sequencing and done pulse.
// Optional rotate-XOR checksum of accepted words when DRAIN_CHECKSUM_EN is defined.
module kernel_stream_drain #(
  parameter int STREAMW = 34,
  parameter int DEPTH   = 4,
  parameter int CNTW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNTW-1:0]    nwords,
  input  logic               kvalid,
  input  logic [STREAMW-1:0] kdata,
  output logic               kready,
  output logic               hvalid,
  output logic [STREAMW-1:0] hdata,
  input  logic               hready,
  output logic               busy,
  output logic               done,
  output logic [CNTW-1:0]    count,
  output logic [STREAMW-1:0] checksum
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state;

  logic [STREAMW-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]    len_q;
  logic               empty, full, accept, pop, job_start;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // kready depends only on registered state so the kernel's ovalid->oready path stays acyclic
  assign kready    = (state == RUN) && !full;
  assign accept    = kvalid && kready;
  assign hvalid    = !empty;
  assign hdata     = mem[rd_ptr[AW-1:0]];
  assign pop       = hvalid && hready;
  assign busy      = (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);
  assign job_start = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr[AW-1:0]] <= kdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count <= '0;
          if (nwords != '0) begin
            len_q <= nwords;
            state <= RUN;
          end else begin
            state <= DONE;
          end
        end
        RUN: if (accept) begin
          count <= count + 1'b1;
          if ((count + 1'b1) == len_q) state <= FLUSH;
        end
        FLUSH: if (empty) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [STREAMW-1:0] cks_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cks_q <= '0;
    else if (job_start) cks_q <= '0;
    else if (accept)    cks_q <= {cks_q[STREAMW-2:0], cks_q[STREAMW-1]} ^ kdata;
  end
  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_kernel_stream_drain.sv
// Randomized bench for kernel_stream_drain against a queue-based job model.
module tb_kernel_stream_drain;
  localparam int STREAMW = 34;
  localparam int DEPTH   = 4;
  localparam int CNTW    = 32;

  logic               clk = 1'b0;
  logic               rst, start, kvalid, hready;
  logic [CNTW-1:0]    nwords;
  logic [STREAMW-1:0] kdata;
  logic               kready, hvalid, busy, done;
  logic [STREAMW-1:0] hdata, checksum;
  logic [CNTW-1:0]    count;

  int compared   = 0;
  int mismatched = 0;

  kernel_stream_drain #(.STREAMW(STREAMW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .nwords(nwords),
    .kvalid(kvalid), .kdata(kdata), .kready(kready),
    .hvalid(hvalid), .hdata(hdata), .hready(hready),
    .busy(busy), .done(done), .count(count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [STREAMW-1:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[STREAMW-1:0];
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_kready"}, kready, 0);
    chk({tag, "_hvalid"}, hvalid, 0);
    chk({tag, "_hdata"}, hdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_cks"}, checksum, 0);
  endtask

  // n: job length; pk/ph: kvalid/hready percent; hold: cycles with hready forced low;
  // seq: data = 1,2,3..; abort_at: reset after that many accepts (0 = none); poke: start mid-job
  task automatic run_job(input int n, input int pk, input int ph, input int hold,
                         input bit seq, input int abort_at, input bit poke);
    logic [STREAMW-1:0] q[$];
    logic [STREAMW-1:0] cks;
    int acc, fin, occ;
    bit ok, poked;
    cks = '0; acc = 0; fin = 0; ok = 0; poked = 0;
    @(negedge clk);
    start = 1'b1; nwords = CNTW'(n); kvalid = 1'b0; hready = 1'b0;
    @(negedge clk);
    start = 1'b0; nwords = CNTW'($urandom_range(1, 50));
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_kready", kready, 0);
      chk("zero_count", count, 0);
      @(negedge clk);
      chk("zero_done_after", done, 0);
      chk("zero_kready_after", kready, 0);
      return;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      occ = q.size();
      if (abort_at != 0 && acc == abort_at) begin
        kvalid = 1'b0; hready = 1'b0;
        #2 rst = 1'b1;
        #1 check_idle_zero("abort");
        #1 rst = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
          chk("abort_no_hvalid", hvalid, 0);
        end
        return;
      end
      chk("kready", kready, (acc < n) && (occ < DEPTH));
      chk("hvalid", hvalid, occ > 0);
      if (occ > 0) chk("hdata", hdata, q[0]);
      chk("done", done, fin == 1);
      chk("busy", busy, fin != 1);
      if (fin == 1) begin ok = 1; break; end
      if (acc == n && occ == 0) fin++;
      kvalid = ($urandom_range(99) < pk);
      kdata  = seq ? STREAMW'(acc + 1) : rand_word();
      hready = (cyc >= hold) && ($urandom_range(99) < ph);
      if (poke && acc == 1 && !poked) begin
        start = 1'b1; nwords = CNTW'($urandom_range(1, 50)); poked = 1;
      end else begin
        start = 1'b0;
      end
      if (kvalid && acc < n && occ < DEPTH) begin
        q.push_back(kdata);
        acc++;
        cks = {cks[STREAMW-2:0], cks[STREAMW-1]} ^ kdata;
      end
      if (hready && occ > 0) void'(q.pop_front());
      @(negedge clk);
    end
    start = 1'b0;
    chk("job_finished", ok, 1);
    chk("count", count, n);
`ifdef DRAIN_CHECKSUM_EN
    chk("checksum", checksum, cks);
`else
    chk("checksum", checksum, 0);
`endif
    @(negedge clk);
    chk("count_hold", count, n);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; nwords = '0; kvalid = 1'b0; kdata = '0; hready = 1'b0;
    #1 check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    run_job(3, 100, 100, 0, 1, 0, 0);         // basic job, data 1,2,3
    run_job(8, 100, 100, 15, 0, 0, 0);        // host stalled: FIFO fills, then drains
    run_job(0, 100, 100, 0, 0, 0, 0);         // zero-length job
    run_job(6, 100, 60, 0, 0, 0, 1);          // start pulsed while running
    run_job(5, 100, 0, 0, 0, 2, 0);           // reset after 2 accepts
    run_job(2, 100, 100, 0, 0, 0, 0);         // recovers after reset
    for (int j = 0; j < 12; j++)
      run_job($urandom_range(1, 20), $urandom_range(20, 100), $urandom_range(20, 100),
              $urandom_range(0, 6), 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
